bit_unpack_ctrl: RTL and testbench
==================================

BIT_UNPACK_CTRL -- requirements
Module: bit_unpack_ctrl

Interface
REQ-001 Parameter MAX_D, default 12: widest output word in bits; legal runtime widths are 1..MAX_D.
REQ-002 Parameter CNT_W, default 9: width of the word-count input; 256 words per polynomial plus one.
REQ-003 Port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle pulse that launches a job; honoured only in IDLE.
REQ-006 Port d_sel, input, 4: bits per output word; sampled on an accepted start.
REQ-007 Port word_count, input, CNT_W: number of words to emit; sampled on an accepted start.
REQ-008 Port in_valid / in_ready, input / output, 1 each: byte-stream handshake.
REQ-009 Port in_data, input, 8: byte payload.
REQ-010 Port out_valid / out_ready, output / input, 1 each: word-stream handshake.
REQ-011 Port out_word, output, MAX_D: unpacked word; bits at and above d are zero.
REQ-012 Port busy, output, 1: high in RUN.
REQ-013 Port done, output, 1: one-cycle pulse when a job completes.
REQ-014 Port err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-015 States SHALL be IDLE and RUN, plus a one-cycle DONE state that returns to IDLE.
REQ-016 IDLE to RUN SHALL occur on start when 1<=d_sel<=MAX_D and word_count!=0; entry latches d and count and clears the bit buffer and the fill and emitted counters.
REQ-017 A start with d_sel=0, d_sel>MAX_D, or word_count=0 SHALL leave the FSM in IDLE and pulse err on the next cycle.
REQ-018 A start while in RUN or DONE SHALL be ignored, with no err pulse.
REQ-019 The bit buffer SHALL be MAX_D+8 bits wide, with fill counter range 0..MAX_D+8.
REQ-020 Bit order is LSB-first: byte bit j maps to stream bit 8*i+j, matching the byte-to-bit conversion order.
REQ-021 An accepted byte SHALL be appended at buffer position fill; out_word is taken from buffer[d-1:0].
REQ-022 in_ready SHALL be 1 only when in RUN and fill<=MAX_D and emitted<count.
REQ-023 out_valid SHALL be 1 only when in RUN and fill>=d; out_word and out_valid are driven from registers with no combinational path from in_data.
REQ-024 On out_valid and out_ready, the buffer SHALL shift right by d, fill decreases by d, and emitted increments.
REQ-025 A byte accept and a word emit in the same cycle SHALL both take effect: new fill = fill-d+8, and the new byte lands at position fill-d.
REQ-026 Latency: a byte accepted at edge t SHALL make its first word visible after edge t, with no further bubble cycles.
REQ-027 out_valid SHALL hold, with out_word stable, until out_ready is sampled high.
REQ-028 When emitted reaches count, the FSM SHALL go to DONE, pulse done, and discard residual buffer bits; no further bytes are accepted.
REQ-029 A fully streaming job SHALL sustain one word per cycle whenever d<=8 and both sides are always ready.

Reset
REQ-030 While rst_n=0: state=IDLE; buffer, fill, emitted, d and count all cleared.
REQ-031 While rst_n=0: in_ready, out_valid, busy, done and err all 0, and out_word=0.
REQ-032 Reset asserted mid-job SHALL abort the job with no done pulse; the first cycle after release is IDLE.

Structure
REQ-033 A shared package kyber_pkg SHALL hold the state enum, MAX_D, CNT_W, and KYBER_N=256.
REQ-034 The block SHALL be a single module with no sub-modules; buffer alignment is a variable shift inside it.

Verification
REQ-035 d=8, count=4, bytes B9 31 E7 E1, both sides always ready -> out_word B9 31 E7 E1, one per cycle, then done pulses once.
REQ-036 d=1, count=8, byte B9 -> words 1,0,0,1,1,1,0,1, then done.
REQ-037 d=12, count=2, bytes B9 31 E7 -> words 1B9 then E73; in_ready drops while fill>12.
REQ-038 d=12 with out_ready toggled randomly at 50% -> every word is held stable until accepted, and no word is lost or duplicated over 256 words.
REQ-039 start with d_sel=0 -> err pulses, busy stays 0; start during RUN -> ignored, and the job completes normally.
REQ-040 rst_n driven low after 100 of 256 words -> all outputs 0 asynchronously, no done pulse, and a fresh job runs correctly after release.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants and state encoding for the Kyber byte-to-word unpacker.
package kyber_pkg;

  localparam int KYBER_N = 256;
  localparam int MAX_D   = 12;
  // One extra count bit so a full polynomial (KYBER_N words) plus one fits.
  localparam int CNT_W   = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_unpack_ctrl.sv
// Unpacks an LSB-first byte stream into d-bit words (1 <= d <= MAX_D).
// All outputs are registers computed from next-state values, so a byte
// accepted on one edge can produce a word visible right after that edge.
module bit_unpack_ctrl
  import kyber_pkg::*;
#(
  parameter int MAX_D = kyber_pkg::MAX_D,
  parameter int CNT_W = kyber_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       d_sel,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAX_D-1:0] out_word,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BUF_W  = MAX_D + 8;
  localparam int FILL_W = $clog2(BUF_W + 1);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   emitted_q, emitted_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [3:0]         d_q, d_d;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [MAX_D-1:0]   out_word_q, out_word_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               take_byte, give_word;
  logic [BUF_W-1:0]   shifted;
  logic [BUF_W-1:0]   byte_ext;
  logic [FILL_W-1:0]  fill_after_emit;
  logic [MAX_D-1:0]   mask_d;

  // Next-state: job launch, byte append, word emit and completion.
  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    fill_d          = fill_q;
    emitted_d       = emitted_q;
    count_d         = count_q;
    d_d             = d_q;
    err_d           = 1'b0;
    take_byte       = in_ready_q & in_valid;
    give_word       = out_valid_q & out_ready;
    shifted         = buf_q;
    fill_after_emit = fill_q;
    byte_ext        = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((d_sel != 4'd0) && (int'(d_sel) <= MAX_D) && (word_count != '0)) begin
            state_d   = ST_RUN;
            d_d       = d_sel;
            count_d   = word_count;
            buf_d     = '0;
            fill_d    = '0;
            emitted_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Emit shifts first so a same-cycle byte lands at fill-d.
        if (give_word) begin
          shifted         = buf_q >> d_q;
          fill_after_emit = fill_q - FILL_W'(d_q);
          emitted_d       = emitted_q + CNT_W'(1);
        end
        byte_ext = BUF_W'(in_data) << fill_after_emit;
        if (take_byte) begin
          buf_d  = shifted | byte_ext;
          fill_d = fill_after_emit + FILL_W'(8);
        end else begin
          buf_d  = shifted;
          fill_d = fill_after_emit;
        end
        if (emitted_d == count_q) begin
          state_d = ST_DONE;
          buf_d   = '0;
          fill_d  = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mask_d      = (MAX_D'(1) << d_d) - MAX_D'(1);
    out_valid_d = (state_d == ST_RUN) && (fill_d >= FILL_W'(d_d));
    out_word_d  = buf_d[MAX_D-1:0] & mask_d;
    in_ready_d  = (state_d == ST_RUN) && (fill_d <= FILL_W'(MAX_D)) && (emitted_d < count_d);
    busy_d      = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      fill_q      <= '0;
      emitted_q   <= '0;
      count_q     <= '0;
      d_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      emitted_q   <= emitted_d;
      count_q     <= count_d;
      d_q         <= d_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bit_unpack_ctrl.sv
// Directed bench for bit_unpack_ctrl: fixed byte/word vectors plus a
// bit-level stream model for the long d=12 jobs.
module tb_bit_unpack_ctrl;

  localparam int MAX_D = 12;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       d_sel = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [MAX_D-1:0] out_word;
  logic             busy;
  logic             done;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]       tbytes [0:511];
  logic [MAX_D-1:0] twords [0:511];

  bit_unpack_ctrl #(.MAX_D(MAX_D), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_sel(d_sel),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_word"}, out_word, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  task automatic start_job(input logic [3:0] d, input int cnt);
    @(negedge clk);
    start = 1'b1; d_sel = d; word_count = CNT_W'(cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model: word k is stream bits d*k .. d*k+d-1, byte i bit j = stream bit 8i+j.
  task automatic build_model(input int d, input int nwords);
    int pos;
    logic [7:0] b;
    for (int k = 0; k < nwords; k++) begin
      twords[k] = '0;
      for (int j = 0; j < d; j++) begin
        pos = d * k + j;
        b = tbytes[pos / 8];
        twords[k][j] = b[pos % 8];
      end
    end
  endtask

  // Drives one job from the current negedge; checks handshake against a
  // fill model (8*bytes_in - d*words_out), word values, hold stability,
  // and the done pulse.
  task automatic run_job(input int d, input int cnt, input int nbytes,
                         input bit rnd_ready, input bit chk_rate,
                         input bit inject_start, input int abort_at);
    int bi = 0, wi = 0, cyc = 0, fill = 0, bubbles = 0;
    bit hold = 1'b0, finished = 1'b0;
    logic [MAX_D-1:0] hw = '0;
    while (cyc < 4000 && !finished) begin
      fill = 8 * bi - d * wi;
      if (abort_at > 0 && wi >= abort_at) begin
        finished = 1'b1;
      end else if (wi == cnt) begin
        check_eq("done_pulse", done, 1);
        check_eq("busy_after", busy, 0);
        check_eq("in_ready_after", in_ready, 0);
        check_eq("out_valid_after", out_valid, 0);
        finished = 1'b1;
      end else begin
        check_eq("busy", busy, 1);
        check_eq("done_early", done, 0);
        check_eq("err_run", err, 0);
        check_eq("in_ready", in_ready, (fill <= MAX_D));
        check_eq("out_valid", out_valid, (fill >= d));
        if (hold) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_word", out_word, hw);
        end
        if (wi > 0 && !out_valid) bubbles++;
        in_valid  = (bi < nbytes);
        in_data   = (bi < nbytes) ? tbytes[bi] : 8'h00;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (inject_start && cyc == 2) begin
          start = 1'b1; d_sel = 4'd3; word_count = CNT_W'(5);
        end else begin
          start = 1'b0;
        end
        if (in_valid && in_ready) bi++;
        if (out_valid && out_ready) begin
          check_eq($sformatf("word%0d", wi), out_word, twords[wi]);
          wi++;
          hold = 1'b0;
        end else if (out_valid) begin
          hold = 1'b1;
          hw = out_word;
        end else begin
          hold = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    if (!finished) check_eq("timeout", 0, 1);
    if (abort_at == 0) begin
      check_eq("word_total", wi, cnt);
      if (chk_rate) check_eq("bubbles", bubbles, 0);
      @(negedge clk);
      check_eq("done_once", done, 0);
      check_eq("idle_busy", busy, 0);
    end
  endtask

  task automatic load_b9_job;
    tbytes[0] = 8'hB9; tbytes[1] = 8'h31; tbytes[2] = 8'hE7; tbytes[3] = 8'hE1;
  endtask

  initial begin
    logic [3:0] bad_d   [4];
    int         bad_cnt [4];
    bad_d = '{4'd0, 4'd13, 4'd15, 4'd5};
    bad_cnt = '{4, 4, 4, 0};

    // Reset state
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // d=8: bytes pass through one word per cycle
    load_b9_job();
    twords[0] = 12'h0B9; twords[1] = 12'h031; twords[2] = 12'h0E7; twords[3] = 12'h0E1;
    start_job(4'd8, 4);
    run_job(8, 4, 4, 1'b0, 1'b1, 1'b0, 0);

    // d=1: single byte B9 LSB first
    twords[0] = 1; twords[1] = 0; twords[2] = 0; twords[3] = 1;
    twords[4] = 1; twords[5] = 1; twords[6] = 0; twords[7] = 1;
    start_job(4'd1, 8);
    run_job(1, 8, 1, 1'b0, 1'b1, 1'b0, 0);

    // d=12: two words from three bytes, in_ready drops at fill 16
    twords[0] = 12'h1B9; twords[1] = 12'hE73;
    start_job(4'd12, 2);
    run_job(12, 2, 3, 1'b0, 1'b0, 1'b0, 0);

    // Rejected starts pulse err, stay idle
    for (int i = 0; i < 4; i++) begin
      start_job(bad_d[i], bad_cnt[i]);
      check_eq($sformatf("err_pulse%0d", i), err, 1);
      check_eq($sformatf("err_busy%0d", i), busy, 0);
      check_eq($sformatf("err_in_ready%0d", i), in_ready, 0);
      @(negedge clk);
      check_eq($sformatf("err_clear%0d", i), err, 0);
      check_eq($sformatf("err_idle%0d", i), busy, 0);
    end

    // Start during RUN is ignored; d=8 job completes unchanged
    load_b9_job();
    twords[0] = 12'h0B9; twords[1] = 12'h031; twords[2] = 12'h0E7; twords[3] = 12'h0E1;
    start_job(4'd8, 4);
    run_job(8, 4, 4, 1'b0, 1'b1, 1'b1, 0);

    // d=12, 256 words, random backpressure
    for (int i = 0; i < 384; i++) tbytes[i] = 8'((i * 37 + 11) & 8'hFF);
    build_model(12, 256);
    start_job(4'd12, 256);
    run_job(12, 256, 384, 1'b1, 1'b0, 1'b0, 0);

    // Reset after 100 words: async clear, no done, clean restart
    for (int i = 0; i < 384; i++) tbytes[i] = 8'((i * 91 + 5) & 8'hFF);
    build_model(12, 256);
    start_job(4'd12, 256);
    run_job(12, 256, 384, 1'b0, 1'b0, 1'b0, 100);
    check_eq("pre_abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_release");
    load_b9_job();
    twords[0] = 12'h0B9; twords[1] = 12'h031; twords[2] = 12'h0E7; twords[3] = 12'h0E1;
    start_job(4'd8, 4);
    run_job(8, 4, 4, 1'b0, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
